// File: rtl/rename_regfile_if.sv
// Decoder/RoB-facing port bundle of the rename register file: source lookup,
// destination rename, checkpoint control, recovery and commit.
interface rename_regfile_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned CKPT_N = 4
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = $clog2(CKPT_N);

  logic             rdy;
  logic [RW-1:0]    rs1;
  logic [RW-1:0]    rs2;
  logic             rs1_rdy;
  logic             rs2_rdy;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [ROB_W-1:0] rs1_rob_pos;
  logic [ROB_W-1:0] rs2_rob_pos;
  logic             issue;
  logic [RW-1:0]    issue_rd;
  logic [ROB_W-1:0] issue_rob_pos;
  logic             ckpt_take;
  logic [CW-1:0]    ckpt_id;
  logic             ckpt_full;
  logic             ckpt_release;
  logic             restore;
  logic [CW-1:0]    restore_id;
  logic             flush;
  logic             commit;
  logic [RW-1:0]    commit_rd;
  logic [XLEN-1:0]  commit_val;
  logic [ROB_W-1:0] commit_rob_pos;

  modport master (
    output rdy, rs1, rs2, issue, issue_rd, issue_rob_pos, ckpt_take,
           ckpt_release, restore, restore_id, flush, commit, commit_rd,
           commit_val, commit_rob_pos,
    input  rs1_rdy, rs2_rdy, rs1_val, rs2_val, rs1_rob_pos, rs2_rob_pos,
           ckpt_id, ckpt_full
  );

  modport slave (
    input  rdy, rs1, rs2, issue, issue_rd, issue_rob_pos, ckpt_take,
           ckpt_release, restore, restore_id, flush, commit, commit_rd,
           commit_val, commit_rob_pos,
    output rs1_rdy, rs2_rdy, rs1_val, rs2_val, rs1_rob_pos, rs2_rob_pos,
           ckpt_id, ckpt_full
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with busy/tag alias table and a ring of branch
// checkpoints. Define RF_BYPASS_EN for commit-to-read forwarding.
module rename_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned CKPT_N = 4
) (
  input logic            clk,
  input logic            rst,
  rename_regfile_if.slave rf
);
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned CW   = $clog2(CKPT_N);
  localparam int unsigned CNTW = CW + 1;

  logic [XLEN-1:0]  val_q [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [ROB_W-1:0] tag_q [NREG];
  logic [ROB_W-1:0] tag_d [NREG];
  logic [NREG-1:0]  cb_q [CKPT_N];
  logic [NREG-1:0]  cb_d [CKPT_N];
  logic [ROB_W-1:0] ct_q [CKPT_N][NREG];
  logic [ROB_W-1:0] ct_d [CKPT_N][NREG];
  logic [CW-1:0]    head_q, head_d, tail_q, tail_d, head_r, rst_off;
  logic [CNTW-1:0]  cnt_q, cnt_d, cnt_r;
  logic             full, commit_ok, issue_ok, rel_ok, restore_ok, take_ok;

  assign full         = (cnt_q == CNTW'(CKPT_N));
  assign rf.ckpt_full = full;
  assign rf.ckpt_id   = tail_q;

  // Next-state of alias table and checkpoint ring; release precedes restore.
  always_comb begin
    busy_d    = busy_q;
    tag_d     = tag_q;
    cb_d      = cb_q;
    ct_d      = ct_q;
    commit_ok = rf.rdy && rf.commit && (rf.commit_rd != '0);
    rel_ok    = rf.rdy && rf.ckpt_release && (cnt_q != '0);
    head_r    = rel_ok ? head_q + CW'(1) : head_q;
    cnt_r     = rel_ok ? cnt_q - CNTW'(1) : cnt_q;
    rst_off   = rf.restore_id - head_r;
    restore_ok = rf.rdy && rf.restore && (CNTW'(rst_off) < cnt_r);
    issue_ok  = rf.rdy && rf.issue && (rf.issue_rd != '0) && !restore_ok;
    take_ok   = rf.rdy && rf.ckpt_take && !full && !restore_ok;
    head_d    = head_r;
    tail_d    = tail_q;
    cnt_d     = cnt_r;

    if (commit_ok) begin
      if (busy_q[rf.commit_rd] && (tag_q[rf.commit_rd] == rf.commit_rob_pos)) begin
        busy_d[rf.commit_rd] = 1'b0;
        tag_d[rf.commit_rd]  = '0;
      end
      for (int unsigned s = 0; s < CKPT_N; s++) begin
        if (cb_q[s][rf.commit_rd] && (ct_q[s][rf.commit_rd] == rf.commit_rob_pos)) begin
          cb_d[s][rf.commit_rd] = 1'b0;
          ct_d[s][rf.commit_rd] = '0;
        end
      end
    end

    if (restore_ok) begin
      busy_d = cb_d[rf.restore_id];
      tag_d  = ct_d[rf.restore_id];
      tail_d = rf.restore_id + CW'(1);
      cnt_d  = CNTW'(rst_off) + CNTW'(1);
    end else begin
      if (issue_ok) begin
        busy_d[rf.issue_rd] = 1'b1;
        tag_d[rf.issue_rd]  = rf.issue_rob_pos;
      end
      if (take_ok) begin
        cb_d[tail_q] = busy_d;
        ct_d[tail_q] = tag_d;
        tail_d       = tail_q + CW'(1);
        cnt_d        = cnt_r + CNTW'(1);
      end
    end

    // Flush is honoured even when rdy is low and overrides everything but commit.
    if (rf.flush) begin
      busy_d = '0;
      for (int unsigned i = 0; i < NREG; i++) tag_d[i] = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      for (int unsigned s = 0; s < CKPT_N; s++) begin
        cb_q[s] <= '0;
        for (int unsigned i = 0; i < NREG; i++) ct_q[s][i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cb_q   <= cb_d;
      ct_q   <= ct_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (commit_ok) val_q[rf.commit_rd] <= rf.commit_val;
    end
  end

  // Combinational read ports; x0 reads as a ready zero.
  always_comb begin
    rf.rs1_rdy     = 1'b1;
    rf.rs1_val     = '0;
    rf.rs1_rob_pos = '0;
    rf.rs2_rdy     = 1'b1;
    rf.rs2_val     = '0;
    rf.rs2_rob_pos = '0;
    if (rf.rs1 != '0) begin
      rf.rs1_rdy     = !busy_q[rf.rs1];
      rf.rs1_val     = val_q[rf.rs1];
      rf.rs1_rob_pos = busy_q[rf.rs1] ? tag_q[rf.rs1] : '0;
`ifdef RF_BYPASS_EN
      if (commit_ok && (rf.rs1 == rf.commit_rd) && busy_q[rf.rs1] &&
          (tag_q[rf.rs1] == rf.commit_rob_pos)) begin
        rf.rs1_rdy     = 1'b1;
        rf.rs1_val     = rf.commit_val;
        rf.rs1_rob_pos = '0;
      end
`endif
    end
    if (rf.rs2 != '0) begin
      rf.rs2_rdy     = !busy_q[rf.rs2];
      rf.rs2_val     = val_q[rf.rs2];
      rf.rs2_rob_pos = busy_q[rf.rs2] ? tag_q[rf.rs2] : '0;
`ifdef RF_BYPASS_EN
      if (commit_ok && (rf.rs2 == rf.commit_rd) && busy_q[rf.rs2] &&
          (tag_q[rf.rs2] == rf.commit_rob_pos)) begin
        rf.rs2_rdy     = 1'b1;
        rf.rs2_val     = rf.commit_val;
        rf.rs2_rob_pos = '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: expected read-port and checkpoint values
// are queued per step and compared just before the next rising edge.
module tb_rename_regfile;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned ROB_W  = 4;
  localparam int unsigned CKPT_N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_regfile_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .CKPT_N(CKPT_N)) bus ();

  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .CKPT_N(CKPT_N)) dut (
    .clk(clk),
    .rst(rst),
    .rf (bus)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    step  = 0;

  function automatic string kname(int k);
    case (k)
      0: return "rs1_rdy";
      1: return "rs1_val";
      2: return "rs1_rob_pos";
      3: return "rs2_rdy";
      4: return "rs2_val";
      5: return "rs2_rob_pos";
      6: return "ckpt_id";
      default: return "ckpt_full";
    endcase
  endfunction

  function automatic logic [31:0] observe(int k);
    case (k)
      0: return 32'(bus.rs1_rdy);
      1: return 32'(bus.rs1_val);
      2: return 32'(bus.rs1_rob_pos);
      3: return 32'(bus.rs2_rdy);
      4: return 32'(bus.rs2_val);
      5: return 32'(bus.rs2_rob_pos);
      6: return 32'(bus.ckpt_id);
      default: return 32'(bus.ckpt_full);
    endcase
  endfunction

  task automatic exp_rs1(input logic r, input logic [31:0] v, input logic [3:0] p);
    sb.push_back('{0, 32'(r)});
    sb.push_back('{1, v});
    sb.push_back('{2, 32'(p)});
  endtask

  task automatic exp_rs2(input logic r, input logic [31:0] v, input logic [3:0] p);
    sb.push_back('{3, 32'(r)});
    sb.push_back('{4, v});
    sb.push_back('{5, 32'(p)});
  endtask

  task automatic exp_ck(input logic [1:0] id, input logic f);
    sb.push_back('{6, 32'(id)});
    sb.push_back('{7, 32'(f)});
  endtask

  task automatic drain();
    item_t       it;
    logic [31:0] o;
    while (sb.size() != 0) begin
      it = sb.pop_front();
      o  = observe(it.kind);
      total++;
      assert (o === it.exp) else begin
        bad++;
        $error("FAIL step%0d %s observed=%0h expected=%0h", step, kname(it.kind), o, it.exp);
      end
    end
  endtask

  // Compare queued expectations before the edge, clock, then drop pulses.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    step++;
    bus.rdy          = 1'b1;
    bus.issue        = 1'b0;
    bus.ckpt_take    = 1'b0;
    bus.ckpt_release = 1'b0;
    bus.restore      = 1'b0;
    bus.flush        = 1'b0;
    bus.commit       = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] t);
    bus.issue = 1'b1; bus.issue_rd = rd; bus.issue_rob_pos = t;
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
    bus.commit = 1'b1; bus.commit_rd = rd; bus.commit_rob_pos = t; bus.commit_val = v;
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd0;
    bus.issue = 1'b0; bus.issue_rd = '0; bus.issue_rob_pos = '0;
    bus.ckpt_take = 1'b0; bus.ckpt_release = 1'b0;
    bus.restore = 1'b0; bus.restore_id = '0; bus.flush = 1'b0;
    bus.commit = 1'b0; bus.commit_rd = '0; bus.commit_val = '0; bus.commit_rob_pos = '0;

    // reset state
    exp_rs1(1'b1, 32'h0, 4'h0); exp_rs2(1'b1, 32'h0, 4'h0); exp_ck(2'd0, 1'b0);
    tick();
    rst = 1'b0;

    // issue then commit with matching tag
    do_issue(5'd5, 4'd3);
    exp_rs1(1'b1, 32'h0, 4'h0);
    tick();
    do_commit(5'd5, 4'd3, 32'hDEAD);
`ifdef RF_BYPASS_EN
    exp_rs1(1'b1, 32'hDEAD, 4'h0);
`else
    exp_rs1(1'b0, 32'h0, 4'h3);
`endif
    tick();
    exp_rs1(1'b1, 32'hDEAD, 4'h0);
    tick();

    // stale commit does not clear a younger producer
    bus.rs1 = 5'd7;
    do_issue(5'd7, 4'd2);
    tick();
    do_issue(5'd7, 4'd6);
    exp_rs1(1'b0, 32'h0, 4'h2);
    tick();
    do_commit(5'd7, 4'd2, 32'd9);
    exp_rs1(1'b0, 32'h0, 4'h6);
    tick();
    exp_rs1(1'b0, 32'd9, 4'h6);
    do_commit(5'd7, 4'd6, 32'd10);
    tick();
    exp_rs1(1'b1, 32'd10, 4'h0);
    tick();

    // same-cycle commit and issue on one register: issue wins
    bus.rs1 = 5'd9;
    do_issue(5'd9, 4'd3);
    tick();
    do_commit(5'd9, 4'd3, 32'd5);
    do_issue(5'd9, 4'd4);
    tick();
    exp_rs1(1'b0, 32'd5, 4'h4);
    tick();

    // checkpoint, younger renames, commit into snapshot, restore
    bus.rs1 = 5'd1; bus.rs2 = 5'd2;
    do_issue(5'd1, 4'd1);
    tick();
    bus.ckpt_take = 1'b1;
    exp_ck(2'd0, 1'b0);
    tick();
    do_issue(5'd1, 4'd4);
    bus.ckpt_take = 1'b1;
    exp_ck(2'd1, 1'b0);
    tick();
    do_issue(5'd2, 4'd5);
    tick();
    do_commit(5'd1, 4'd1, 32'h77);
    exp_rs1(1'b0, 32'h0, 4'h4);
    tick();
    bus.restore = 1'b1; bus.restore_id = 2'd0;
    do_issue(5'd3, 4'd7);
    exp_rs1(1'b0, 32'h77, 4'h4); exp_rs2(1'b0, 32'h0, 4'h5); exp_ck(2'd2, 1'b0);
    tick();
    exp_rs1(1'b1, 32'h77, 4'h0); exp_rs2(1'b1, 32'h0, 4'h0); exp_ck(2'd1, 1'b0);
    tick();
    bus.rs1 = 5'd3;
    exp_rs1(1'b1, 32'h0, 4'h0);
    bus.ckpt_release = 1'b1;
    tick();
    exp_ck(2'd1, 1'b0);
    bus.flush = 1'b1;
    tick();

    // fill ring, overfill, release with wrap
    for (int i = 0; i < 4; i++) begin
      bus.ckpt_take = 1'b1;
      exp_ck(2'(i), 1'b0);
      tick();
    end
    exp_ck(2'd0, 1'b1);
    bus.ckpt_take = 1'b1;
    tick();
    exp_ck(2'd0, 1'b1);
    bus.ckpt_release = 1'b1;
    tick();
    exp_ck(2'd0, 1'b0);
    bus.restore = 1'b1; bus.restore_id = 2'd0;
    bus.rs1 = 5'd4;
    do_issue(5'd4, 4'd8);
    tick();
    exp_rs1(1'b0, 32'h0, 4'h8); exp_ck(2'd0, 1'b0);
    tick();

    // asynchronous reset mid-run with busy registers and three live slots
    bus.rs1 = 5'd5; bus.rs2 = 5'd4;
    rst = 1'b1;
    #1;
    exp_rs1(1'b1, 32'h0, 4'h0); exp_rs2(1'b1, 32'h0, 4'h0); exp_ck(2'd0, 1'b0);
    tick();
    rst = 1'b0;

    // rdy low holds state; flush still applies
    bus.rs1 = 5'd8; bus.rs2 = 5'd6;
    bus.rdy = 1'b0;
    do_issue(5'd8, 4'd1);
    tick();
    exp_rs1(1'b1, 32'h0, 4'h0);
    do_issue(5'd6, 4'd9);
    tick();
    bus.ckpt_take = 1'b1;
    exp_rs2(1'b0, 32'h0, 4'h9);
    tick();
    bus.rdy = 1'b0; bus.flush = 1'b1;
    do_issue(5'd3, 4'd2);
    exp_ck(2'd1, 1'b0);
    tick();
    bus.rs1 = 5'd3;
    exp_rs1(1'b1, 32'h0, 4'h0); exp_rs2(1'b1, 32'h0, 4'h0); exp_ck(2'd0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
